// File: rtl/systolic_output_writer.sv
// Collects skewed column results from the systolic array, rebuilds full result rows,
// and commits each row to RAM, gating the matmul FSM through the rdy/done handshake.
module systolic_output_writer #(
  parameter int          ROWS           = 4,
  parameter int          COLS           = 4,
  parameter int          WORD_SIZE      = 16,
  parameter logic [31:0] OUT_BASE_ADDR  = 32'h0000_0200,
  parameter int          ADDR_INCR      = 4,
  parameter int          MEM_PORT_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_fsm,
  input  logic                      fsm_done,
  input  logic                      stall,
  input  logic [COLS*WORD_SIZE-1:0] matmul_output,
  input  logic [COLS-1:0]           output_col_valid,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] mem_wr_data,
  input  logic                      mem_gnt,
  output logic                      ovf_err,
  output logic [1:0]                fsm_state
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cap_cnt [COLS];
  logic [CNT_W-1:0]   wr_row;
  logic [CNT_W-1:0]   wr_row_nxt;
  logic [WORD_SIZE-1:0] row_buf [ROWS][COLS];
  logic               wr_pending;
  logic               wr_fire;
  logic [IDX_W-1:0]   rd_idx;
  logic [31:0]        row_offset;

  assign fsm_state = state_q;

  // Valid/ready: a row write is offered on mem_wr_en with address and data held
  // stable; the transfer happens on each rising edge where mem_wr_en and mem_gnt are both 1.
  assign wr_pending = (state_q == S_COLLECT) && (wr_row < cap_cnt[COLS-1]);
  assign wr_fire    = wr_pending && mem_gnt;
  assign wr_row_nxt = wr_fire ? wr_row + CNT_W'(1) : wr_row;
  assign rd_idx     = wr_row[IDX_W-1:0];
  assign row_offset = 32'(wr_row) * 32'(ADDR_INCR);

  always_comb begin
    state_d        = state_q;
    wr_output_rdy  = 1'b0;
    wr_output_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_output_rdy = 1'b1;
        if (start_fsm) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // Look ahead at the post-grant row pointer so done follows the last grant directly.
        if (wr_row_nxt == ROWS_C && fsm_done) state_d = S_DONE;
      end
      S_DONE: begin
        wr_output_done = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en   = wr_pending;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (wr_pending) begin
      mem_addr = OUT_BASE_ADDR + row_offset;
      for (int c = 0; c < COLS; c++) begin
        mem_wr_data[c*WORD_SIZE +: WORD_SIZE] = row_buf[rd_idx][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_row  <= '0;
      ovf_err <= 1'b0;
      for (int c = 0; c < COLS; c++) cap_cnt[c] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_fsm) begin
            wr_row <= '0;
            for (int c = 0; c < COLS; c++) cap_cnt[c] <= '0;
          end
        end
        S_COLLECT: begin
          wr_row <= wr_row_nxt;
          if (!stall) begin
            for (int c = 0; c < COLS; c++) begin
              if (output_col_valid[c]) begin
                if (cap_cnt[c] < ROWS_C) cap_cnt[c] <= cap_cnt[c] + CNT_W'(1);
                else                     ovf_err    <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result storage needs no reset: rows are only read after being captured in this pass.
  always_ff @(posedge clk) begin
    if (state_q == S_COLLECT && !stall) begin
      for (int c = 0; c < COLS; c++) begin
        if (output_col_valid[c] && cap_cnt[c] < ROWS_C) begin
          row_buf[cap_cnt[c][IDX_W-1:0]][c] <= matmul_output[c*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_writer.sv
// Directed bench for systolic_output_writer: reset values, row reassembly, stall gating,
// overflow, write backpressure, early/late done timing and reset during a pending write.
module tb_systolic_output_writer;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int MPW  = 64;

  logic              clk;
  logic              rst;
  logic              start_fsm;
  logic              fsm_done;
  logic              stall;
  logic [COLS*W-1:0] matmul_output;
  logic [COLS-1:0]   output_col_valid;
  logic              wr_output_rdy;
  logic              wr_output_done;
  logic [31:0]       mem_addr;
  logic              mem_wr_en;
  logic [MPW-1:0]    mem_wr_data;
  logic              mem_gnt;
  logic              ovf_err;
  logic [1:0]        fsm_state;

  systolic_output_writer dut (
    .clk              (clk),
    .rst              (rst),
    .start_fsm        (start_fsm),
    .fsm_done         (fsm_done),
    .stall            (stall),
    .matmul_output    (matmul_output),
    .output_col_valid (output_col_valid),
    .wr_output_rdy    (wr_output_rdy),
    .wr_output_done   (wr_output_done),
    .mem_addr         (mem_addr),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .mem_gnt          (mem_gnt),
    .ovf_err          (ovf_err),
    .fsm_state        (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int done_cnt = 0;
  int done_edge = -1;
  int last_acc_edge = -1;
  logic [95:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; log any write accepted at that edge against the expected queue.
  task automatic tick();
    logic        acc;
    logic [95:0] got;
    acc = mem_wr_en & mem_gnt;
    got = {mem_addr, mem_wr_data};
    @(posedge clk);
    #1;
    cyc++;
    if (acc === 1'b1) begin
      n_acc++;
      last_acc_edge = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL unexpected_write: observed 0x%0h expected no write", got);
      end else begin
        check("write_addr_data", got, exp_q.pop_front());
      end
    end
    if (wr_output_done === 1'b1) begin
      done_cnt++;
      done_edge = cyc;
    end
  endtask

  task automatic push_basic();
    exp_q.push_back({32'h0000_0200, 64'h0003_0002_0001_0000});
    exp_q.push_back({32'h0000_0204, 64'h0013_0012_0011_0010});
    exp_q.push_back({32'h0000_0208, 64'h0023_0022_0021_0020});
    exp_q.push_back({32'h0000_020C, 64'h0033_0032_0031_0030});
  endtask

  // Column c delivers row r at step r+c, value 16*r+c.
  task automatic feed_skewed();
    for (int t = 0; t < ROWS + COLS - 1; t++) begin
      output_col_valid = '0;
      matmul_output    = '0;
      for (int c = 0; c < COLS; c++) begin
        if (t - c >= 0 && t - c < ROWS) begin
          output_col_valid[c]       = 1'b1;
          matmul_output[c*W +: W]   = 16'(16 * (t - c) + c);
        end
      end
      tick();
    end
    output_col_valid = '0;
    matmul_output    = '0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, 1);
  endtask

  task automatic basic_pass(input string tag);
    push_basic();
    n_acc     = 0;
    done_cnt  = 0;
    fsm_done  = 1'b1;
    mem_gnt   = 1'b1;
    start_fsm = 1'b1;
    tick();
    start_fsm = 1'b0;
    check({tag, "_rdy_low"}, wr_output_rdy, 1'b0);
    check({tag, "_state_collect"}, fsm_state, 2'd1);
    feed_skewed();
    wait_done(20);
    check({tag, "_done_after_last_grant"}, done_edge, last_acc_edge);
    check({tag, "_all_rows_written"}, exp_q.size(), 0);
    check({tag, "_write_count"}, n_acc, 4);
    tick();
    check({tag, "_rdy_back"}, wr_output_rdy, 1'b1);
    check({tag, "_done_low"}, wr_output_done, 1'b0);
    tick();
    check({tag, "_idle_ignores_fsm_done"}, fsm_state, 2'd0);
    check({tag, "_single_done_pulse"}, done_cnt, 1);
    fsm_done = 1'b0;
  endtask

  initial begin
    rst              = 1'b0;
    start_fsm        = 1'b0;
    fsm_done         = 1'b0;
    stall            = 1'b0;
    matmul_output    = '0;
    output_col_valid = '0;
    mem_gnt          = 1'b0;

    // reset values
    tick();
    tick();
    check("rst_rdy", wr_output_rdy, 1'b1);
    check("rst_done", wr_output_done, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", mem_wr_data, 64'h0);
    check("rst_ovf", ovf_err, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst = 1'b1;
    tick();
    check("idle_rdy", wr_output_rdy, 1'b1);

    // basic 4x4 with fsm_done already high (early done)
    basic_pass("basic");

    // stall gating, overflow, backpressure, late fsm_done
    n_acc     = 0;
    done_cnt  = 0;
    fsm_done  = 1'b0;
    mem_gnt   = 1'b1;
    start_fsm = 1'b1;
    tick();
    start_fsm = 1'b0;
    output_col_valid = 4'b0001;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      matmul_output = {48'h0, 16'(16'hBAD0 + i)};
      tick();
    end
    stall = 1'b0;
    matmul_output = {48'h0, 16'h1000};
    tick();
    for (int r = 1; r < 4; r++) begin
      matmul_output = {48'h0, 16'(16'h1000 + r)};
      tick();
    end
    check("stall_single_capture_no_ovf", ovf_err, 1'b0);
    output_col_valid = 4'b0010;
    for (int r = 0; r < 4; r++) begin
      matmul_output = {32'h0, 16'(16'h1100 + r), 16'h0};
      tick();
    end
    output_col_valid = 4'b0100;
    for (int r = 0; r < 4; r++) begin
      matmul_output = {16'h0, 16'(16'h1200 + r), 32'h0};
      tick();
    end
    check("ovf_before_fifth", ovf_err, 1'b0);
    matmul_output = {16'h0, 16'h12FF, 32'h0};
    tick();
    check("ovf_after_fifth", ovf_err, 1'b1);

    exp_q.push_back({32'h0000_0200, 64'h1300_1200_1100_1000});
    exp_q.push_back({32'h0000_0204, 64'h1301_1201_1101_1001});
    exp_q.push_back({32'h0000_0208, 64'h1302_1202_1102_1002});
    exp_q.push_back({32'h0000_020C, 64'h1303_1203_1103_1003});
    mem_gnt = 1'b0;
    output_col_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) matmul_output = {16'(16'h1300 + k), 48'h0};
      else begin
        output_col_valid = '0;
        matmul_output    = '0;
      end
      tick();
      check("bp_wr_en", mem_wr_en, 1'b1);
      check("bp_addr", mem_addr, 32'h0000_0200);
      check("bp_data", mem_wr_data, 64'h1300_1200_1100_1000);
    end
    mem_gnt = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    check("bp_all_rows_written", exp_q.size(), 0);
    check("bp_write_count", n_acc, 4);
    for (int n = 0; n < 10; n++) tick();
    check("late_no_done_yet", done_cnt, 0);
    check("late_rdy_low", wr_output_rdy, 1'b0);
    fsm_done = 1'b1;
    tick();
    check("late_done_pulse", wr_output_done, 1'b1);
    check("late_done_at_fsm_done_edge", done_edge, cyc);
    fsm_done = 1'b0;
    tick();
    check("late_rdy_back", wr_output_rdy, 1'b1);
    check("late_done_low", wr_output_done, 1'b0);
    check("ovf_sticky", ovf_err, 1'b1);

    // reset while a write is pending
    mem_gnt   = 1'b0;
    start_fsm = 1'b1;
    tick();
    start_fsm = 1'b0;
    output_col_valid = 4'b1111;
    matmul_output    = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    output_col_valid = '0;
    matmul_output    = '0;
    check("mid_pending_wr_en", mem_wr_en, 1'b1);
    rst = 1'b0;
    tick();
    check("mid_rst_wr_en", mem_wr_en, 1'b0);
    check("mid_rst_rdy", wr_output_rdy, 1'b1);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_data", mem_wr_data, 64'h0);
    check("mid_rst_ovf", ovf_err, 1'b0);
    rst = 1'b1;
    tick();
    basic_pass("clean");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
